// File: rtl/esm_sched_pkg.sv
// Shared types and sizing helpers for the ESM issue scheduler.
package esm_sched_pkg;

  typedef enum logic [1:0] {
    SlotFree,
    SlotWaiting,
    SlotIssued
  } slot_state_t;

  localparam int unsigned BsDefault         = 16;
  localparam int unsigned InstrWidthDefault = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/esm_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, wrapping at N-1.
module esm_rr_arbiter
  import esm_sched_pkg::*;
#(
  parameter int unsigned N = BsDefault,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [IdxW-1:0] probe;

  // Walk offsets from high to low so the smallest offset wins; N is a power of two so
  // IdxW-bit addition wraps naturally.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    probe       = '0;
    for (int unsigned k = N; k > 0; k--) begin
      probe = ptr_i + IdxW'(k - 1);
      if (req_i[probe]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = probe;
      end
    end
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Slot allocator and round-robin issue controller in front of the ESM dependency core.
module esm_issue_scheduler
  import esm_sched_pkg::*;
#(
  parameter int unsigned Instr_word_size = InstrWidthDefault,
  parameter int unsigned bs = BsDefault,
  localparam int unsigned IdxW = idx_width(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] Instr_in,
  output logic [Instr_word_size-1:0] core_instr,
  output logic [IdxW-1:0]            buffer_index,
  input  logic [bs-1:0]              ready_positions,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [IdxW-1:0]            issue_index,
  output logic [Instr_word_size-1:0] issue_instr,
  input  logic                       complete_valid,
  input  logic [IdxW-1:0]            complete_index,
  output logic [IdxW:0]              occupancy,
  output logic                       err_bad_complete
);

  slot_state_t                state_q [bs];
  slot_state_t                state_d [bs];
  logic [Instr_word_size-1:0] word_q  [bs];
  logic [Instr_word_size-1:0] word_d  [bs];

  logic [IdxW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                       issue_valid_q, issue_valid_d;
  logic [IdxW-1:0]            issue_index_q, issue_index_d;
  logic [Instr_word_size-1:0] issue_instr_q, issue_instr_d;
  logic [IdxW:0]              occ_q, occ_d;
  logic                       err_q, err_d;

  logic [bs-1:0]   free_vec, eligible;
  logic [IdxW-1:0] alloc_idx, gnt_idx;
  logic            gnt_valid, fire_in, alloc, hs, comp_ok, load_issue;

  // The slot currently held in the issue register is masked so it is never picked twice.
  always_comb begin
    free_vec  = '0;
    eligible  = '0;
    alloc_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      free_vec[i] = (state_q[i] == SlotFree);
      eligible[i] = (state_q[i] == SlotWaiting) && ready_positions[i] &&
                    !(issue_valid_q && (issue_index_q == IdxW'(i)));
      if (state_q[i] == SlotFree) alloc_idx = IdxW'(i);
    end
  end

  esm_rr_arbiter #(
    .N(bs)
  ) u_arb (
    .req_i      (eligible),
    .ptr_i      (rr_ptr_q),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  assign in_ready     = |free_vec;
  assign fire_in      = in_valid && in_ready;
  assign alloc        = fire_in && (Instr_in != '0);
  assign buffer_index = in_ready ? alloc_idx : '0;
  assign core_instr   = fire_in ? Instr_in : '0;
  assign hs           = issue_valid_q && issue_ready;
  assign load_issue   = !issue_valid_q || issue_ready;
  assign comp_ok      = complete_valid && (state_q[complete_index] == SlotIssued);

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_index_d = issue_index_q;
    issue_instr_d = issue_instr_q;
    occ_d         = occ_q;
    err_d         = err_q;

    if (comp_ok) state_d[complete_index] = SlotFree;
    if (complete_valid && !comp_ok) err_d = 1'b1;

    if (hs) begin
      state_d[issue_index_q] = SlotIssued;
      rr_ptr_d               = issue_index_q + 1'b1;
    end

    if (alloc) begin
      state_d[alloc_idx] = SlotWaiting;
      word_d[alloc_idx]  = Instr_in;
    end

    if (load_issue) begin
      issue_valid_d = gnt_valid;
      if (gnt_valid) begin
        issue_index_d = gnt_idx;
        issue_instr_d = word_q[gnt_idx];
      end
    end

    unique case ({alloc, comp_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        state_q[i] <= SlotFree;
        word_q[i]  <= '0;
      end
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      issue_instr_q <= '0;
      occ_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      issue_instr_q <= issue_instr_d;
      occ_q         <= occ_d;
      err_q         <= err_d;
    end
  end

  assign issue_valid      = issue_valid_q;
  assign issue_index      = issue_index_q;
  assign issue_instr      = issue_instr_q;
  assign occupancy        = occ_q;
  assign err_bad_complete = err_q;

endmodule

// File: doc/esm_issue_scheduler.md
Name: esm_issue_scheduler

Overview:
Issue controller for the ESM dependency-analysis core.
- Accepts a decoded instruction stream and allocates a free instruction-buffer slot to each instruction.
- Drives the core's instruction and buffer-index inputs and stores each instruction word per slot.
- Uses the core's ready_positions vector to issue dependency-free slots to the execute stage through a valid/ready handshake, round-robin fair.
- Frees slots on completion from execute.

Parameters:
Instr_word_size, 32, instruction word width
bs, 16, buffer slots; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  scheduler can accept (a free slot exists)
Instr_in  in  Instr_word_size  upstream instruction word
core_instr  out  Instr_word_size  to core Instr_in; Instr_in on accept, else all-zero (null)
buffer_index  out  $clog2(bs)  to core; slot allocated this cycle (0 when no accept)
ready_positions  in  bs  from core; bit i = slot i has no outstanding dependency
issue_valid  out  1  issue request to execute
issue_ready  in  1  execute accepts
issue_index  out  $clog2(bs)  slot being issued
issue_instr  out  Instr_word_size  stored word of issued slot
complete_valid  in  1  execute finished a slot
complete_index  in  $clog2(bs)  slot finished
occupancy  out  $clog2(bs)+1  number of non-FREE slots
err_bad_complete  out  1  sticky; completion hit a non-ISSUED slot

Behaviour:
- Slot state per slot: FREE -> WAITING (on allocate) -> ISSUED (on issue handshake) -> FREE (on complete). No other transitions.
- Reset (synchronous, rst=1 at posedge):
  - All slots FREE.
  - Round-robin pointer = 0.
  - issue_valid=0, issue_index=0, issue_instr=0, occupancy=0, err_bad_complete=0.
  - in_ready follows combinationally and is 1 after reset.
  - Reset mid-operation discards all slot contents and any pending issue. No completion is expected afterwards; one that arrives sets the error flag.
- Accept:
  - in_ready = any slot FREE. This uses registered state only; a slot freed this cycle is not visible until the next cycle.
  - fire_in = in_valid & in_ready.
  - Allocated slot = lowest-index FREE slot. buffer_index presents that index combinationally whenever in_ready, else 0.
- Null instruction (Instr_in == 0 with fire_in):
  - Consumed and dropped. No slot changes state.
  - core_instr = 0 and occupancy is unchanged.
- Non-null fire_in:
  - core_instr = Instr_in.
  - At the clock edge: slot word is stored and slot -> WAITING.
  - Without fire_in, core_instr = 0.
- Eligibility: eligible[i] = (state[i]==WAITING) & ready_positions[i] & ~(issue_valid & issue_index==i). A slot allocated at edge t is first eligible in cycle t+1, when the core's table has updated.
- Selection: round-robin.
  - Pick the first eligible index at or after the pointer, wrapping from bs-1 to 0.
  - The pointer moves to issued index + 1 (mod bs) on each issue handshake only.
- Issue output register:
  - If issue_valid=0 or (issue_valid & issue_ready), load the new pick at the edge if any eligible, else clear issue_valid.
  - Latency: eligible in cycle n -> issue_valid in cycle n+1. Back-to-back issue is possible every cycle.
  - While issue_valid & ~issue_ready: issue_index and issue_instr are held stable, even if ready_positions for that slot drops.
  - On handshake, the slot goes ISSUED at that edge.
- Completion:
  - complete_valid with state[complete_index]==ISSUED: slot -> FREE at the edge.
  - Otherwise the completion is ignored and err_bad_complete is set (sticky until rst).
- Simultaneous events: allocate, issue handshake and complete may occur in the same cycle on distinct slots; all take effect. The same slot cannot be involved in two of them, because the slot states are mutually exclusive.
- occupancy is registered: += 1 on non-null allocate, -= 1 on valid completion, both possible in one cycle (net 0). Range 0..bs.

Decomposition:
- Package esm_sched_pkg:
  - slot_state_t enum {FREE, WAITING, ISSUED}.
  - Index width function and constant for bs default.
- Sub-module esm_rr_arbiter (bs-wide request vector plus pointer in; grant index and grant-valid out; purely combinational).
- Slot word storage stays in this block as a bs x Instr_word_size register array.

Test Plan:
- Reset, then 3 non-null instructions on consecutive cycles, ready_positions=all 1, issue_ready=1 -> buffer_index 0,1,2; issue_index 0,1,2 in cycles 2,3,4; occupancy reaches 3.
- Fill all 16 slots with issue_ready=0 -> in_ready=0 after the 16th accept. Then complete_valid/complete_index=5 after issuing slot 5 -> in_ready=1 one cycle later; next buffer_index=5.
- Instr_in=0 with in_valid -> core_instr=0, occupancy unchanged, no issue.
- Slots 1,3,7 WAITING and ready, pointer=4 -> issue order 7,1,3.
- Hold issue_ready=0 for 5 cycles while ready_positions[issue_index] toggles -> issue_index/issue_instr stable; a single handshake when released.
- complete_index of a WAITING slot -> err_bad_complete=1 and stays 1; slot state unchanged. Assert rst mid-stream -> all outputs return to their reset values next cycle.
